imem_loader: RTL and testbench

Instruction-memory loader for the MIPS single-cycle core: the write side of the program ROM path. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word into the instruction memory at consecutive word indices, which map to byte addresses starting at 0x00400000. It holds the core in reset while loading and flags completion.

---
 rtl/imem_loader_pkg.sv | 7 +
 rtl/imem_loader_byte_packer.sv | 27 ++
 rtl/imem_loader.sv | 84 ++++++++
 tb/tb_imem_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and address-map constants for the instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} loader_state_t;
  localparam logic [31:0] ROM_BASE = 32'h00400000;
  localparam logic [31:0] RAM_BASE = 32'h10010000;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four accepted bytes into a little-endian word; word_full flags the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_full
);
  logic [3:0] lane_en;
  assign lane_en = en ? 4'b0001 << byte_cnt : 4'b0000;
  assign word_full = en && byte_cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
      byte_cnt <= '0;
    end else begin
      byte_cnt <= clr ? 2'd0 : en ? byte_cnt + 2'd1 : byte_cnt;
      for (int i = 0; i < BYTES_PER_WORD; i++)
        if (lane_en[i]) word[8*i +: 8] <= byte_in;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into 32-bit instruction-memory words while holding the core in reset.
// Optional running checksum enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      word_count,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_waddr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  output logic                 core_hold,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] checksum
);
  loader_state_t state;
  logic [ADDR_W:0] cnt, clamp;
  logic accept, clr, word_full, last;
  logic [1:0] byte_cnt;
  assign clamp = word_count > (ADDR_W+1)'(DEPTH_WORDS) ? (ADDR_W+1)'(DEPTH_WORDS) : word_count;
  assign accept = byte_ready && byte_valid;
  assign clr = start && (state == IDLE || state == DONE);
  assign last = {1'b0, mem_waddr} == cnt - 1'b1;
  byte_packer u_packer (
    .clk(clk), .reset(reset), .clr(clr), .en(accept), .byte_in(byte_in),
    .word(mem_wdata), .byte_cnt(byte_cnt), .word_full(word_full)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_waddr <= '0;
      byte_ready <= 1'b0;
      mem_we <= 1'b0;
      core_hold <= 1'b0;
      done <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          cnt <= clamp;
          mem_waddr <= '0;
          state <= clamp == '0 ? DONE : LOAD;
          done <= clamp == '0;
          byte_ready <= clamp != '0;
          core_hold <= clamp != '0;
        end
        LOAD: if (word_full) begin
          state <= WRITE;
          byte_ready <= 1'b0;
          mem_we <= 1'b1;
        end
        WRITE: if (last) begin
          state <= DONE;
          done <= 1'b1;
          core_hold <= 1'b0;
        end else begin
          mem_waddr <= mem_waddr + 1'b1;
          state <= LOAD;
          byte_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [BIT_WIDTH-1:0] sum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum <= '0;
    else sum <= clr ? '0 : mem_we ? sum + mem_wdata : sum;
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads plus corner sequences, with a write scoreboard checked on mem_we.
module tb_imem_loader;
  localparam int DEPTH = 256;
  logic clk = 0, reset_n = 0, start = 0, byte_valid = 0;
  logic [8:0] word_count = '0;
  logic [7:0] byte_in = '0, mem_waddr;
  logic byte_ready, mem_we, core_hold, done;
  logic [31:0] mem_wdata, checksum;
  int total = 0, pass = 0, nwrites = 0;
  logic [7:0] last_addr = '0;

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t q[$];

  typedef struct { int wc; bit gap; logic [31:0] w0; logic [31:0] w1; } vec_t;
  vec_t vt[6];

  imem_loader dut (
    .clk(clk), .reset(reset_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  always @(negedge clk) if (mem_we === 1'b1) begin
    wr_t e;
    nwrites++;
    last_addr = mem_waddr;
    chk("ready_low_in_write", {31'b0, byte_ready}, 32'h0);
    if (q.size() == 0) chk("unexpected_write", 32'h1, 32'h0);
    else begin
      e = q.pop_front();
      chk("waddr", {24'b0, mem_waddr}, {24'b0, e.a});
      chk("wdata", mem_wdata, e.d);
    end
  end

  task automatic check_reset();
    chk("rst_ready", {31'b0, byte_ready}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_waddr", {24'b0, mem_waddr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", {31'b0, core_hold}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_checksum", checksum, 0);
  endtask

  task automatic start_load(input int wc);
    word_count = 9'(wc);
    start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    byte_valid = 1;
    byte_in = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
    end
    if (!ok) chk("byte_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1 byte_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    chk("done_reached", {31'b0, ok}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] w, s;
    int n0;
    vt[0] = '{0, 0, 32'h0, 32'h0};
    vt[1] = '{2, 0, 32'h12345678, 32'hDEADBEEF};
    vt[2] = '{1, 1, 32'hCAFEF00D, 32'h0};
    vt[3] = '{2, 1, 32'h0BADF00D, 32'hFFFFFFFF};
    vt[4] = '{0, 0, 32'h0, 32'h0};
    vt[5] = '{1, 0, 32'h80000001, 32'h0};

    #12 check_reset();
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      s = 0;
      n0 = nwrites;
      start_load(vt[i].wc);
      @(negedge clk);
      chk("done_after_start", {31'b0, done}, {31'b0, vt[i].wc == 0});
      chk("ready_after_start", {31'b0, byte_ready}, {31'b0, vt[i].wc != 0});
      chk("hold_after_start", {31'b0, core_hold}, {31'b0, vt[i].wc != 0});
      @(posedge clk); #1;
      for (int j = 0; j < vt[i].wc; j++) begin
        w = j == 0 ? vt[i].w0 : vt[i].w1;
        q.push_back('{8'(j), w});
        s += w;
        send_word(w, vt[i].gap);
      end
      wait_done();
      chk("writes", nwrites - n0, vt[i].wc);
      chk("hold_done", {31'b0, core_hold}, 0);
      chk("checksum", checksum, exp_sum(s));
      chk("queue_empty", q.size(), 0);
    end

    start_load(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset_n = 0;
    #2 check_reset();
    @(posedge clk); @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
    q.push_back('{8'd0, 32'h44332211});
    start_load(1);
    send_word(32'h44332211, 0);
    wait_done();
    chk("post_reset_queue", q.size(), 0);

    q.push_back('{8'd0, 32'h0F1E2D3C});
    start_load(1);
    send_byte(8'h3C);
    send_byte(8'h2D);
    start_load(5);
    @(negedge clk);
    chk("start_in_load_hold", {31'b0, core_hold}, 1);
    chk("start_in_load_ready", {31'b0, byte_ready}, 1);
    @(posedge clk); #1;
    send_byte(8'h1E);
    send_byte(8'h0F);
    wait_done();
    chk("start_in_load_queue", q.size(), 0);
    chk("start_in_load_sum", checksum, exp_sum(32'h0F1E2D3C));

    s = 0;
    n0 = nwrites;
    start_load(DEPTH + 5);
    for (int j = 0; j < DEPTH; j++) begin
      w = $urandom;
      q.push_back('{8'(j), w});
      s += w;
      send_word(w, 0);
    end
    wait_done();
    chk("depth_writes", nwrites - n0, DEPTH);
    chk("depth_last_addr", {24'b0, last_addr}, DEPTH - 1);
    chk("depth_checksum", checksum, exp_sum(s));
    chk("depth_queue", q.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk("no_extra_writes", nwrites - n0, DEPTH);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
